// File: rtl/sa_seq_pkg.sv
// Shared types and sizing helpers for the systolic-array operand sequencer.
package sa_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_I,
    STORE,
    DONE
  } seq_state_t;

  function automatic int elems_f(input int n);
    return n * n;
  endfunction

  function automatic int bytes_per_phase_f(input int elems);
    return (elems + 1) / 2;
  endfunction

endpackage

// File: rtl/sa_nibble_unpack.sv
// One-byte unpack buffer: presents the low element, then the high element,
// and can take the next byte in the same cycle its high element leaves.
module sa_nibble_unpack
  import sa_seq_pkg::*;
#(
  parameter int BITWIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  more,
  input  logic                  consume_last,
  input  logic [2*BITWIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  elem_valid,
  output logic [BITWIDTH-1:0]   elem_data
);

  logic [2*BITWIDTH-1:0] buf_q;
  logic                  full_q;
  logic                  half_q;
  logic                  slot_free;

  assign elem_valid = full_q && enable;
  assign elem_data  = half_q ? buf_q[2*BITWIDTH-1:BITWIDTH] : buf_q[BITWIDTH-1:0];

  // The slot frees up when the buffer is empty, its high element leaves now,
  // or the phase's last element leaves now (its high half is thrown away).
  assign slot_free = !full_q || half_q || consume_last;
  assign in_ready  = enable && slot_free && more;

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      buf_q  <= '0;
      full_q <= 1'b0;
      half_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      buf_q  <= in_data;
      full_q <= 1'b1;
      half_q <= 1'b0;
    end else if (full_q) begin
      if (half_q || consume_last) begin
        full_q <= 1'b0;
        half_q <= 1'b0;
      end else begin
        half_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sa_operand_sequencer.sv
// Sequences weight, input and store phases for the systolic array.
// Optional store-phase watchdog: define SA_SEQ_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for start, input not accepted
// LOAD_W | streaming ELEMS weight elements
// LOAD_I | streaming ELEMS input elements
// STORE  | draining array, counting res_valid
// DONE   | one-cycle completion pulse
module sa_operand_sequencer
  import sa_seq_pkg::*;
#(
  parameter int BITWIDTH = 4,
  parameter int N        = 2,
  parameter int RESULTS  = N * N,
  parameter int TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2*BITWIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BITWIDTH-1:0]   data_out,
  output logic                  load_weights,
  output logic                  load_inputs,
  output logic                  store_outputs,
  input  logic                  res_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

  localparam int ELEMS = elems_f(N);
  localparam int EW    = $clog2(ELEMS + 1);
  localparam int RW    = $clog2(RESULTS + 1);

  seq_state_t          state_q, state_d;
  logic [EW-1:0]       elem_cnt_q;
  logic [RW-1:0]       res_cnt_q;
  logic [BITWIDTH-1:0] data_q;
  logic                load_phase;
  logic                elem_valid;
  logic [BITWIDTH-1:0] elem_data;
  logic                last_elem;
  logic                more;
  logic                consume_last;
  logic                res_last;
  logic                wd_expired;

  assign load_phase   = (state_q == LOAD_W) || (state_q == LOAD_I);
  assign last_elem    = (elem_cnt_q == EW'(ELEMS - 1));
  assign consume_last = elem_valid && last_elem;
  // A weight phase is always followed by an input phase, so a byte can be
  // taken for the inputs while the last weight element is still leaving.
  assign more         = (state_q == LOAD_W) || !elem_valid || !last_elem;
  assign res_last     = (res_cnt_q == RW'(RESULTS - 1));
  assign data_out     = elem_valid ? elem_data : data_q;

  sa_nibble_unpack #(.BITWIDTH(BITWIDTH)) u_unpack (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (load_phase),
    .more         (more),
    .consume_last (consume_last),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .elem_valid   (elem_valid),
    .elem_data    (elem_data)
  );

  always_comb begin
    state_d       = state_q;
    load_weights  = 1'b0;
    load_inputs   = 1'b0;
    store_outputs = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = LOAD_W;
      end
      LOAD_W: begin
        load_weights = elem_valid;
        if (consume_last) state_d = LOAD_I;
      end
      LOAD_I: begin
        load_inputs = elem_valid;
        if (consume_last) state_d = STORE;
      end
      STORE: begin
        store_outputs = 1'b1;
        if ((res_valid && res_last) || wd_expired) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      elem_cnt_q <= '0;
      res_cnt_q  <= '0;
      data_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        elem_cnt_q <= '0;
        res_cnt_q  <= '0;
      end else begin
        if (elem_valid) elem_cnt_q <= elem_cnt_q + 1'b1;
        if (state_q == STORE && res_valid) res_cnt_q <= res_cnt_q + 1'b1;
      end
      if (elem_valid) data_q <= elem_data;
    end
  end

`ifdef SA_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wd_q;
  logic          err_q;

  assign wd_expired  = (state_q == STORE) && !res_valid && (wd_q == '0);
  assign timeout_err = err_q;

  // Down-counter reloaded on STORE entry and on every res_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == IDLE && start) err_q <= 1'b0;
      else if (wd_expired)         err_q <= 1'b1;
      if (state_d == STORE && (state_q != STORE || res_valid)) wd_q <= TW'(TIMEOUT - 1);
      else if (state_q == STORE && wd_q != '0)                  wd_q <= wd_q - 1'b1;
    end
  end
`else
  assign wd_expired  = 1'b0;
  // Constant 0; written this way so TIMEOUT stays referenced without the watchdog.
  assign timeout_err = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_sa_operand_sequencer.sv
// Randomized self-checking bench for sa_operand_sequencer against a
// byte-to-element reference model.
module tb_sa_operand_sequencer;

  localparam int BW      = 4;
  localparam int N       = 2;
  localparam int ELEMS   = N * N;
  localparam int RESULTS = N * N;
  localparam int TIMEOUT = 8;
  localparam int BPP     = (ELEMS + 1) / 2;

  typedef logic [2*BW-1:0] bq_t[$];
  typedef struct {
    int     kind;
    int     val;
    longint at;
  } strobe_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2*BW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] data_out;
  logic          load_weights;
  logic          load_inputs;
  logic          store_outputs;
  logic          res_valid;
  logic          busy;
  logic          done;
  logic          timeout_err;

  int        n_tests = 0;
  int        n_fail  = 0;
  longint    cyc     = 0;
  strobe_t   strobes[$];

  sa_operand_sequencer #(
    .BITWIDTH (BW),
    .N        (N),
    .RESULTS  (RESULTS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .data_out      (data_out),
    .load_weights  (load_weights),
    .load_inputs   (load_inputs),
    .store_outputs (store_outputs),
    .res_valid     (res_valid),
    .busy          (busy),
    .done          (done),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (load_weights) strobes.push_back('{1, int'(data_out), cyc});
      if (load_inputs)  strobes.push_back('{2, int'(data_out), cyc});
      check("one_hot", (int'(load_weights) + int'(load_inputs) + int'(store_outputs)) > 1, 0);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_load_w"}, load_weights, 0);
    check({tag, "_load_i"}, load_inputs, 0);
    check({tag, "_store"}, store_outputs, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_terr"}, timeout_err, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("terr_after_start", timeout_err, 0);
  endtask

  task automatic send_bytes(input bq_t bq, input int gmin, input int gmax, input bit noise);
    int g;
    int budget;
    bit acc;
    for (int i = 0; i < bq.size(); i++) begin
      if (i > 0) begin
        g = $urandom_range(gmax, gmin);
        repeat (g) begin
          in_valid  = 1'b0;
          res_valid = noise && ($urandom_range(0, 3) == 0);
          start     = noise && ($urandom_range(0, 3) == 0);
          @(negedge clk);
        end
      end
      acc    = 1'b0;
      budget = 0;
      while (!acc) begin
        in_valid  = 1'b1;
        in_data   = bq[i];
        res_valid = noise && ($urandom_range(0, 3) == 0);
        start     = noise && ($urandom_range(0, 3) == 0);
        acc       = in_ready;
        @(negedge clk);
        budget++;
        if (!acc && budget > 20) begin
          check("in_ready_wait", 0, 1);
          break;
        end
      end
    end
    in_valid  = 1'b0;
    res_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic wait_store();
    int k = 0;
    while (!store_outputs && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("store_entry", store_outputs, 1);
  endtask

  // Reference: each phase takes ELEMS elements from its own BPP bytes,
  // low element first, dropping the unused high half of an odd phase.
  task automatic check_seq(input bq_t bq);
    int exp_kind;
    int exp_val;
    logic [2*BW-1:0] b;
    check("n_strobes", strobes.size(), 2 * ELEMS);
    for (int i = 0; i < 2 * ELEMS && i < strobes.size(); i++) begin
      exp_kind = (i / ELEMS) + 1;
      b        = bq[(i / ELEMS) * BPP + (i % ELEMS) / 2];
      exp_val  = ((i % ELEMS) % 2 == 1) ? int'(b) / (1 << BW) : int'(b) % (1 << BW);
      check("strobe_kind", strobes[i].kind, exp_kind);
      check("strobe_val", strobes[i].val, exp_val);
    end
  endtask

  task automatic drive_results(input int gmax);
    int g;
    for (int r = 0; r < RESULTS; r++) begin
      g = $urandom_range(gmax, 0);
      repeat (g) begin
        check("store_hold", store_outputs, 1);
        check("no_early_done", done, 0);
        @(negedge clk);
      end
      res_valid = 1'b1;
      check("store_at_res", store_outputs, 1);
      @(negedge clk);
      res_valid = 1'b0;
    end
    check("done_pulse", done, 1);
    check("store_fall", store_outputs, 0);
    check("busy_in_done", busy, 1);
    @(negedge clk);
    check("done_single", done, 0);
    check("busy_after", busy, 0);
  endtask

  task automatic run_op(input bq_t bq, input int gmin, input int gmax, input bit noise,
                        input bit gapless);
    strobes.delete();
    do_start();
    send_bytes(bq, gmin, gmax, noise);
    wait_store();
    check_seq(bq);
    if (gapless && strobes.size() == 2 * ELEMS)
      check("gapless_span", int'(strobes[2*ELEMS-1].at - strobes[0].at), 2 * ELEMS - 1);
    if (gmin == gmax && gmin > 0 && strobes.size() >= 3)
      check("gap_bubble", int'(strobes[2].at - strobes[1].at), gmin);
    drive_results(2);
  endtask

  initial begin
    bq_t bq;
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    res_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    in_valid  = 1'b1;
    in_data   = 8'h5A;
    res_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_in_ready", in_ready, 0);
      check("idle_busy", busy, 0);
      check("idle_load_w", load_weights, 0);
    end
    in_valid  = 1'b0;
    res_valid = 1'b0;

    bq = '{8'h21, 8'h43, 8'h65, 8'h87};
    run_op(bq, 0, 0, 1'b0, 1'b1);

    bq = '{8'h21, 8'h43, 8'h65, 8'h87};
    run_op(bq, 3, 3, 1'b0, 1'b0);

    strobes.delete();
    do_start();
    bq = '{8'h21, 8'h43};
    send_bytes(bq, 0, 0, 1'b0);
    #1;
    check("pre_reset_strobes", strobes.size(), 3);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", busy, 0);

    bq = '{8'hDC, 8'hFE, 8'h10, 8'h32};
    run_op(bq, 0, 1, 1'b0, 1'b0);

    bq = '{8'h21, 8'h43, 8'h65, 8'h87};
    run_op(bq, 0, 2, 1'b1, 1'b0);

    for (int t = 0; t < 15; t++) begin
      bq.delete();
      for (int j = 0; j < 2 * BPP; j++) bq.push_back(8'($urandom));
      run_op(bq, 0, 3, 1'b1, 1'b0);
    end

`ifdef SA_SEQ_TIMEOUT_EN
    begin
      int k;
      strobes.delete();
      do_start();
      bq = '{8'h21, 8'h43, 8'h65, 8'h87};
      send_bytes(bq, 0, 0, 1'b0);
      wait_store();
      k = 0;
      while (store_outputs && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("timeout_cycles", k, TIMEOUT);
      check("timeout_done", done, 1);
      check("timeout_err_set", timeout_err, 1);
      @(negedge clk);
      check("timeout_err_sticky", timeout_err, 1);
      check("timeout_idle", busy, 0);
      bq = '{8'h98, 8'hBA, 8'hDC, 8'hFE};
      run_op(bq, 0, 1, 1'b0, 1'b0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule
